// File: rtl/bm_memory_arbiter_pkg.sv
// Shared defaults and requester indices for the two-port memory arbiter.
package bm_memory_arbiter_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int NUM_REQ        = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/bm_memory_arbiter_core.sv
// Single-access register-file memory: write on the clock edge, registered read.
module bm_memory_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/bm_memory_arbiter.sv
// Two-port round-robin arbiter serializing read/write accesses into one memory core.
module bm_memory_arbiter
  import bm_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1
);
  logic                               last;
  logic                               sel;
  logic                               any_gnt;
  logic                               mem_we;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [DATA_WIDTH-1:0]              mem_wdata;
  logic [DATA_WIDTH-1:0]              core_rdata;
  logic                               rd_vld;
  logic                               rd_owner;
  logic [NUM_REQ-1:0]                 rvalid_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_v;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case ({req1, req0})
        2'b01:   gnt0 = 1'b1;
        2'b10:   gnt1 = 1'b1;
        2'b11: begin
          gnt0 = (last == REQ1);
          gnt1 = (last == REQ0);
        end
        default: ;
      endcase
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel       = gnt1 ? REQ1 : REQ0;
  assign mem_we    = any_gnt & (sel ? we1 : we0);
  assign mem_addr  = sel ? addr1 : addr0;
  assign mem_wdata = sel ? wdata1 : wdata0;

  bm_memory_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_addr),
    .raddr (mem_addr),
    .wdata (mem_wdata),
    .rdata (core_rdata)
  );

  // rd_vld/rd_owner mark that core_rdata holds a granted read for one requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      last     <= REQ1;
      rd_vld   <= 1'b0;
      rd_owner <= REQ0;
    end else begin
      if (any_gnt) last <= sel;
      rd_vld   <= any_gnt & ~mem_we;
      rd_owner <= sel;
    end
  end

  // Per-requester steering: live core data while valid, otherwise the held copy.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
    logic                  hit;
    logic [DATA_WIDTH-1:0] hold;

    assign hit         = rd_vld && (rd_owner == 1'(i));
    assign rvalid_v[i] = hit;
    assign rdata_v[i]  = hit ? core_rdata : hold;

    always_ff @(posedge clock) begin
      if (reset)    hold <= '0;
      else if (hit) hold <= core_rdata;
    end
  end

  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];
endmodule

// File: tb/tb_bm_memory_arbiter.sv
// Directed bench for bm_memory_arbiter with hand-computed expectations.
module tb_bm_memory_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  bm_memory_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .gnt0    (gnt0),
    .rvalid0 (rvalid0),
    .rdata0  (rdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .gnt1    (gnt1),
    .rvalid1 (rvalid1),
    .rdata1  (rdata1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after posedge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] tput_exp [4];

  initial begin
    tput_exp[0] = 8'h5C;
    tput_exp[1] = 8'h11;
    tput_exp[2] = 8'hA5;
    tput_exp[3] = 8'h33;

    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0; wdata1 = 8'h00;
    tick();
    tick();
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);

    // Single requester: write A5 to addr 2, then read it back.
    reset = 1'b0; req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
    #1;
    chk("single_wr_gnt0", gnt0, 1);
    chk("single_wr_gnt1", gnt1, 0);
    tick();
    we0 = 1'b0;
    #1;
    chk("single_rd_gnt0", gnt0, 1);
    chk("single_wr_no_rvalid", rvalid0, 0);
    tick();
    req0 = 1'b0;
    #1;
    chk("single_rvalid0", rvalid0, 1);
    chk("single_rdata0", rdata0, 8'hA5);
    chk("single_rvalid1", rvalid1, 0);
    chk("single_idle_gnt0", gnt0, 0);
    tick();
    #1;
    chk("single_rvalid0_drop", rvalid0, 0);
    chk("single_rdata0_hold", rdata0, 8'hA5);

    // Preload 0x11 @1 and 0x33 @3, then reset so the pointer starts fresh.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h11;
    tick();
    addr0 = 2'd3; wdata0 = 8'h33;
    tick();
    req0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
    #1;
    chk("rr_c0_gnt0", gnt0, 1);
    chk("rr_c0_gnt1", gnt1, 0);
    tick();
    #1;
    chk("rr_c1_gnt1", gnt1, 1);
    chk("rr_c1_gnt0", gnt0, 0);
    chk("rr_c1_rvalid0", rvalid0, 1);
    chk("rr_c1_rdata0", rdata0, 8'h11);
    chk("rr_c1_rvalid1", rvalid1, 0);
    tick();
    #1;
    chk("rr_c2_gnt0", gnt0, 1);
    chk("rr_c2_rvalid1", rvalid1, 1);
    chk("rr_c2_rdata1", rdata1, 8'h33);
    chk("rr_c2_rvalid0", rvalid0, 0);
    tick();
    #1;
    chk("rr_c3_gnt1", gnt1, 1);
    chk("rr_c3_rvalid0", rvalid0, 1);
    chk("rr_c3_rdata0", rdata0, 8'h11);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rr_end_rvalid1", rvalid1, 1);
    chk("rr_end_rdata1", rdata1, 8'h33);
    chk("rr_end_gnt0", gnt0, 0);
    chk("rr_end_gnt1", gnt1, 0);
    tick();

    // Write vs read of the same address right after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h5C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
    #1;
    chk("raw_gnt0_first", gnt0, 1);
    chk("raw_gnt1_wait", gnt1, 0);
    tick();
    req0 = 1'b0;
    #1;
    chk("raw_gnt1_next", gnt1, 1);
    tick();
    req1 = 1'b0;
    #1;
    chk("raw_rvalid1", rvalid1, 1);
    chk("raw_rdata1", rdata1, 8'h5C);
    chk("raw_rvalid0", rvalid0, 0);
    tick();

    // Full throughput: req1 alone reads addr 0..3 back to back.
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; we1 = 1'b0; addr1 = 2'(i);
      #1;
      chk($sformatf("tput_gnt1_%0d", i), gnt1, 1);
      if (i > 0) begin
        chk($sformatf("tput_rvalid1_%0d", i - 1), rvalid1, 1);
        chk($sformatf("tput_rdata1_%0d", i - 1), rdata1, tput_exp[i-1]);
      end
      tick();
    end
    req1 = 1'b0;
    #1;
    chk("tput_rvalid1_3", rvalid1, 1);
    chk("tput_rdata1_3", rdata1, tput_exp[3]);
    tick();
    #1;
    chk("tput_rvalid1_drop", rvalid1, 0);

    // Reset lands on the edge that would have returned a granted read.
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
    #1;
    chk("mid_gnt1", gnt1, 1);
    reset = 1'b1; req1 = 1'b0;
    tick();
    #1;
    chk("mid_rvalid1", rvalid1, 0);
    chk("mid_rdata1", rdata1, 0);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    #1;
    chk("mid_post_gnt0", gnt0, 1);
    chk("mid_post_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0;
    #1;
    chk("mid_post_rvalid0", rvalid0, 1);
    chk("mid_post_rdata0", rdata0, 8'h33);
    chk("mid_post_gnt1_next", gnt1, 1);
    tick();
    req1 = 1'b0;
    #1;
    chk("mid_post_rvalid1", rvalid1, 1);
    chk("mid_post_rdata1", rdata1, 8'h11);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge clock) begin
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL onehot_gnt: got gnt0=%0b gnt1=%0b expected not both", gnt0, gnt1);
    end
  end
endmodule

// File: doc/bm_memory_arbiter.md
Name: bm_memory_arbiter

Overview:
- Two-port round-robin arbiter in front of a small single-access register-file memory (4 words x 8 bits by default).
- Two independent requesters each issue read or write accesses. At most one access is serviced per clock.
- Read data returns one cycle after grant, tagged per requester.
- Used in micro benchmarks to exercise memory inference behind simple sequential control.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of the wdata/rdata buses.
- ADDR_WIDTH, 2, address width. Memory depth is 2**ADDR_WIDTH words (4 by default).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 access request; level, held until granted.
- we0  input  1  requester 0: 1 = write, 0 = read; valid while req0 = 1.
- addr0  input  ADDR_WIDTH  requester 0 address.
- wdata0  input  DATA_WIDTH  requester 0 write data.
- gnt0  output  1  requester 0 granted this cycle (combinational).
- rvalid0  output  1  requester 0 read data valid (registered).
- rdata0  output  DATA_WIDTH  requester 0 read data (registered).
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1.

Behaviour:
- Reset values: rvalid0 = rvalid1 = 0; rdata0 = rdata1 = 0; priority pointer last = 1, so requester 0 wins the first contention.
- While reset = 1: gnt0 = gnt1 = 0; no memory write occurs.
- Memory contents are not reset and are undefined until written.
- Arbitration is combinational, evaluated each cycle with reset = 0:
  - only req0 -> gnt0 = 1.
  - only req1 -> gnt1 = 1.
  - both requesting -> grant the requester that is not "last".
  - neither requesting -> no grant; "last" is unchanged.
- Invariant: gnt0 and gnt1 are never both 1.
- On a posedge with a grant, "last" is updated to the granted requester index.
- Granted write (we = 1): mem[addr] <= wdata at that edge. No rvalid is produced.
- Granted read (we = 0): at that edge rdata_g <= mem[addr] and rvalid_g <= 1. Read latency is 1 cycle from the grant cycle.
- rvalid for a requester is 1 for exactly one cycle per granted read, otherwise 0.
- rdata holds its last value when rvalid = 0.
- Read-after-write: a read granted in the cycle after a write to the same address returns the new data.
- No same-cycle conflict can arise, because accesses are serialized.
- Requesters hold req/we/addr/wdata stable until they observe gnt.
  - A requester that deasserts req before being granted loses the access; no side effect.
- Back-to-back: a requester holding req while the other is idle is granted every cycle (one access per cycle, full throughput).
- Reset asserted mid-operation:
  - A read granted in the cycle before reset: its rvalid/rdata are overwritten by the reset values at the same edge (rvalid = 0), so that read's data is lost.
  - Pointer returns to last = 1.
  - Memory keeps its contents.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, requester index constants REQ0 = 0 and REQ1 = 1.
- One sub-module, bm_memory_core: clock, we, waddr/raddr (shared address), wdata, rdata, with registered read.
  - The arbiter muxes the granted requester's fields into the core.
  - The arbiter steers rdata into rdata0/rdata1 using a 1-bit registered "read owner" and a registered read flag.

Test Plan:
- Reset: hold reset 2 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
- Single requester: req0 writes 0xA5 to addr 2, then reads addr 2 on the next cycle -> gnt0 = 1 both cycles; rvalid0 = 1 with rdata0 = 0xA5 one cycle after the read grant; rvalid1 stays 0.
- Contention round-robin: after reset, both hold read requests (addr0 = 1, addr1 = 3, preloaded 0x11 and 0x33) for 4 cycles -> grants alternate 0,1,0,1; rvalid0/rdata0 = 0x11 and rvalid1/rdata1 = 0x33 on alternating cycles.
- Simultaneous write vs read of the same address: req0 writes 0x5C to addr 0, req1 reads addr 0, both in the same cycle after reset -> req0 granted first; req1 granted next cycle and returns 0x5C.
- Full throughput: req1 alone issues reads of addr 0..3 on consecutive cycles -> gnt1 = 1 every cycle; rvalid1 = 1 for 4 consecutive cycles with data in address order.
- Reset mid-read: req1 read of addr 3 granted in the cycle before reset asserts -> at the next edge rvalid1 = 0; after release, contention grants req0 first; memory addr 3 still reads 0x33.
